// File: rtl/alu_pkg.sv
// Shared definitions for the board-demo ALU: operation codes, mode bank
// selects, push-button codes and the blank segment pattern, plus the
// decoder that maps (mode, buttons) onto an operation.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_MOD,
    OP_AND,
    OP_XOR,
    OP_OR,
    OP_SHL,
    OP_SHR,
    OP_NONE
  } op_e;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LOGIC = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;

  // Active-low buttons: exactly one bit low selects a slot.
  localparam logic [3:0] BTN_0 = 4'b1110;
  localparam logic [3:0] BTN_1 = 4'b1101;
  localparam logic [3:0] BTN_2 = 4'b1011;
  localparam logic [3:0] BTN_3 = 4'b0111;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anything not listed (no button, several buttons, unused slot or bank)
  // decodes to OP_NONE.
  function automatic op_e decode_op(input logic [1:0] mode, input logic [3:0] btn);
    op_e op;
    op = OP_NONE;
    case (mode)
      MODE_ARITH: begin
        case (btn)
          BTN_0:   op = OP_ADD;
          BTN_1:   op = OP_SUB;
          BTN_2:   op = OP_MUL;
          BTN_3:   op = OP_DIV;
          default: op = OP_NONE;
        endcase
      end
      MODE_LOGIC: begin
        case (btn)
          BTN_0:   op = OP_MOD;
          BTN_1:   op = OP_AND;
          BTN_2:   op = OP_XOR;
          BTN_3:   op = OP_OR;
          default: op = OP_NONE;
        endcase
      end
      MODE_SHIFT: begin
        case (btn)
          BTN_0:   op = OP_SHL;
          BTN_1:   op = OP_SHR;
          default: op = OP_NONE;
        endcase
      end
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_hex_to_7seg.sv
// Combinational hex digit to 7-segment decoder.
// Ports:
//   hex : 4-bit value to display
//   seg : active-low segments, bit order {g,f,e,d,c,b,a}
module hex_to_7seg
  import alu_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered N-bit ALU for the board demo. Operation chosen by a 2-bit
// mode bank and four active-low buttons; results shown on 7-seg digits.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   A_num, B_num        : operands (B is also the shift amount)
//   operations_buttons  : active-low op select within the bank
//   change_mode         : op bank select
//   seg1, seg2          : digits of A_num[3:0], B_num[3:0]
//   result_seg          : digit of result[3:0]
//   flags_seg           : digit of flag nibble {Nf,Z,C,V}
module alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  input  logic [3:0]   operations_buttons,
  input  logic [1:0]   change_mode,
  output logic [6:0]   seg1,
  output logic [6:0]   seg2,
  output logic [6:0]   result_seg,
  output logic [6:0]   flags_seg
);

  typedef logic [N-1:0] word_t;

  op_e          op;
  word_t        alu_res;
  logic         alu_c;
  logic         alu_v;
  logic [N:0]   wide;
  logic [2*N-1:0] prod;

  word_t        result_q;
  logic [3:0]   flags_q;
  word_t        res_next;
  logic [3:0]   flags_next;

  logic [6:0]   seg_a;
  logic [6:0]   seg_b;
  logic [6:0]   seg_res;
  logic [6:0]   seg_flags;

  assign op = decode_op(change_mode, operations_buttons);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    prod    = '0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, A_num} + {1'b0, B_num};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (A_num[N-1] == B_num[N-1]) && (alu_res[N-1] != A_num[N-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (A < B).
        wide    = {1'b0, A_num} - {1'b0, B_num};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (A_num[N-1] != B_num[N-1]) && (alu_res[N-1] != A_num[N-1]);
      end
      OP_MUL: begin
        prod    = {{N{1'b0}}, A_num} * {{N{1'b0}}, B_num};
        alu_res = prod[N-1:0];
        alu_c   = |prod[2*N-1:N];
      end
      OP_DIV: begin
        if (B_num == '0) begin
          alu_res = '1;
          alu_v   = 1'b1;
        end else begin
          alu_res = A_num / B_num;
        end
      end
      OP_MOD: begin
        if (B_num == '0) begin
          alu_res = A_num;
          alu_v   = 1'b1;
        end else begin
          alu_res = A_num % B_num;
        end
      end
      OP_AND: alu_res = A_num & B_num;
      OP_XOR: alu_res = A_num ^ B_num;
      OP_OR:  alu_res = A_num | B_num;
      // Shifting through one extra bit leaves the last bit shifted out in
      // that extra position; a zero shift naturally leaves it 0.
      OP_SHL: begin
        if (B_num < word_t'(N)) begin
          wide    = {1'b0, A_num} << B_num;
          alu_res = wide[N-1:0];
          alu_c   = wide[N];
        end
      end
      OP_SHR: begin
        if (B_num < word_t'(N)) begin
          wide    = {A_num, 1'b0} >> B_num;
          alu_res = wide[N:1];
          alu_c   = wide[0];
        end
      end
      default: ;
    endcase
  end

  // Invalid selections keep the previous result and flags on display.
  always_comb begin
    if (op != OP_NONE) begin
      res_next   = alu_res;
      flags_next = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
    end else begin
      res_next   = result_q;
      flags_next = flags_q;
    end
  end

  hex_to_7seg u_hex_a     (.hex(A_num[3:0]),    .seg(seg_a));
  hex_to_7seg u_hex_b     (.hex(B_num[3:0]),    .seg(seg_b));
  hex_to_7seg u_hex_res   (.hex(res_next[3:0]), .seg(seg_res));
  hex_to_7seg u_hex_flags (.hex(flags_next),    .seg(seg_flags));

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      flags_q    <= '0;
      seg1       <= SEG_BLANK;
      seg2       <= SEG_BLANK;
      result_seg <= SEG_BLANK;
      flags_seg  <= SEG_BLANK;
    end else begin
      result_q   <= res_next;
      flags_q    <= flags_next;
      seg1       <= seg_a;
      seg2       <= seg_b;
      result_seg <= seg_res;
      flags_seg  <= seg_flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] A_num;
  logic [3:0] B_num;
  logic [3:0] operations_buttons;
  logic [1:0] change_mode;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] result_seg;
  logic [6:0] flags_seg;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  alu #(.N(4)) dut (
    .clk(clk),
    .rst(rst),
    .A_num(A_num),
    .B_num(B_num),
    .operations_buttons(operations_buttons),
    .change_mode(change_mode),
    .seg1(seg1),
    .seg2(seg2),
    .result_seg(result_seg),
    .flags_seg(flags_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] btn;
    logic [1:0] mode;
    logic [3:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] btn, input logic [1:0] mode);
    @(negedge clk);
    A_num = a;
    B_num = b;
    operations_buttons = btn;
    change_mode = mode;
  endtask

  task automatic add(input string name, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] btn, input logic [1:0] mode,
                     input logic [3:0] res, input logic [3:0] flags);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.btn = btn; v.mode = mode;
    v.res = res; v.flags = flags;
    vecs.push_back(v);
  endtask

  initial begin
    // name, A, B, buttons, mode, expected result digit, expected flags {Nf,Z,C,V}
    add("add_carry",    4'b1011, 4'b0110, 4'b1110, 2'b00, 4'h1, 4'h2);
    add("sub_zero",     4'b1111, 4'b1111, 4'b1101, 2'b00, 4'h0, 4'h4);
    add("mul_c",        4'b0110, 4'b0010, 4'b1011, 2'b00, 4'hC, 4'h8);
    add("mul_f",        4'b0101, 4'b0011, 4'b1011, 2'b00, 4'hF, 4'h8);
    add("div",          4'b0011, 4'b0010, 4'b0111, 2'b00, 4'h1, 4'h0);
    add("div_by0",      4'b0011, 4'b0000, 4'b0111, 2'b00, 4'hF, 4'h9);
    add("add_ovf",      4'b0111, 4'b0001, 4'b1110, 2'b00, 4'h8, 4'h9);
    add("sub_borrow",   4'b0010, 4'b0101, 4'b1101, 2'b00, 4'hD, 4'hA);
    add("sub_ovf",      4'b1000, 4'b0001, 4'b1101, 2'b00, 4'h7, 4'h1);
    add("mul_hi",       4'b1000, 4'b0010, 4'b1011, 2'b00, 4'h0, 4'h6);
    add("mod",          4'b0110, 4'b0011, 4'b1110, 2'b01, 4'h0, 4'h4);
    add("mod_by0",      4'b0111, 4'b0000, 4'b1110, 2'b01, 4'h7, 4'h1);
    add("and",          4'b0111, 4'b0110, 4'b1101, 2'b01, 4'h6, 4'h0);
    add("xor",          4'b1001, 4'b0111, 4'b1011, 2'b01, 4'hE, 4'h8);
    add("or",           4'b1010, 4'b1010, 4'b0111, 2'b01, 4'hA, 4'h8);
    add("shl2",         4'b1100, 4'b0010, 4'b1110, 2'b10, 4'h0, 4'h6);
    add("shr3",         4'b1010, 4'b0011, 4'b1101, 2'b10, 4'h1, 4'h0);
    add("shr1",         4'b1001, 4'b0001, 4'b1101, 2'b10, 4'h4, 4'h2);
    add("shr0",         4'b1001, 4'b0000, 4'b1101, 2'b10, 4'h9, 4'h8);
    add("shl_ge_n",     4'b1111, 4'b0100, 4'b1110, 2'b10, 4'h0, 4'h4);
    add("shl1",         4'b0011, 4'b0001, 4'b1110, 2'b10, 4'h6, 4'h0);
    // Last bit shifted out of 1010<<3 is A[1]=1.
    add("shl3",         4'b1010, 4'b0011, 4'b1110, 2'b10, 4'h0, 4'h6);
    add("hold_2btn",    4'b0101, 4'b0001, 4'b1100, 2'b00, 4'h0, 4'h6);
    add("hold_mode11",  4'b0001, 4'b0010, 4'b1110, 2'b11, 4'h0, 4'h6);
    add("hold_slot",    4'b0011, 4'b0100, 4'b0111, 2'b10, 4'h0, 4'h6);
    add("hold_nobtn",   4'b1110, 4'b1101, 4'b1111, 2'b01, 4'h0, 4'h6);

    rst = 1'b1;
    A_num = 4'b0000;
    B_num = 4'b0000;
    operations_buttons = 4'b1111;
    change_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg1",  seg1,       7'b1111111);
    check("rst_seg2",  seg2,       7'b1111111);
    check("rst_res",   result_seg, 7'b1111111);
    check("rst_flags", flags_seg,  7'b1111111);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].btn, vecs[i].mode);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_seg1"},  seg1,       seg_of(vecs[i].a));
      check({vecs[i].name, "_seg2"},  seg2,       seg_of(vecs[i].b));
      check({vecs[i].name, "_res"},   result_seg, seg_of(vecs[i].res));
      check({vecs[i].name, "_flags"}, flags_seg,  seg_of(vecs[i].flags));
    end

    // Latency: a new op is not visible before the next edge, then is.
    drive(4'b0010, 4'b0011, 4'b1110, 2'b00);
    #1;
    check("lat_before_res", result_seg, seg_of(4'h0));
    @(posedge clk);
    #1;
    check("lat_after_res",   result_seg, seg_of(4'h5));
    check("lat_after_flags", flags_seg,  seg_of(4'h0));

    // Reset mid-run blanks displays and clears the held result/flags.
    drive(4'b0010, 4'b0011, 4'b1110, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_res",   result_seg, 7'b1111111);
    check("rst2_flags", flags_seg,  7'b1111111);
    drive(4'b1001, 4'b0110, 4'b1111, 2'b00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_hold_res",   result_seg, seg_of(4'h0));
    check("post_rst_hold_flags", flags_seg,  seg_of(4'h0));
    check("post_rst_seg1",       seg1,       seg_of(4'h9));
    check("post_rst_seg2",       seg2,       seg_of(4'h6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
